// File: rtl/uc_multiciclo.sv
// rtl/uc_multiciclo.sv - multicycle FETCH/DECODE/EXEC control unit driving the FD datapath
// Control outputs are registered; decode is taken from the fetched word as it is loaded into IR.
module uc_multiciclo #(
  parameter int              PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [PC_W-1:0] imem_addr,
  output logic            imem_req,
  input  logic            imem_valid,
  input  logic [31:0]     imem_data,
  output logic [4:0]      Ra,
  output logic [4:0]      Rb,
  output logic [4:0]      Rw,
  output logic            WE_reg,
  output logic            WE_mem,
  output logic [PC_W-1:0] OFFSET,
  output logic [1:0]      OP_MEM_I,
  output logic            ADD_SUB,
  input  logic [5:0]      flags,
  output logic [PC_W-1:0] pc,
  output logic            halted,
  output logic            illegal
);

  typedef enum logic [1:0] {S_FETCH, S_DECODE, S_EXEC, S_HALT} state_t;

  localparam logic [6:0] OPC_REG    = 7'b0110011;
  localparam logic [6:0] OPC_ADDI   = 7'b0010011;
  localparam logic [6:0] OPC_SUBI   = 7'b0001011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  state_t          state_q;
  logic [PC_W-1:0] pc_q;
  logic [31:0]     ir_q;
  logic [4:0]      ra_q, rb_q, rw_q;
  logic [PC_W-1:0] off_q;
  logic [1:0]      op_q;
  logic            sub_q;
  logic            we_reg_q, we_mem_q;
  logic            req_q;
  logic            halted_q, illegal_q;

  logic [31:0]     word;
  logic [6:0]      opc;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [PC_W-1:0] imm_i, imm_s, imm_b;
  logic            dec_legal, dec_wreg, dec_wmem, dec_br, dec_sub;
  logic [4:0]      dec_ra, dec_rb, dec_rw;
  logic [PC_W-1:0] dec_off;
  logic [1:0]      dec_op;
  logic            br_taken;
  logic [PC_W-1:0] pc_seq_d, pc_tgt_d;

  // While fetching, decode the incoming word so the registered controls are valid in DECODE.
  always_comb begin
    word  = (state_q == S_FETCH) ? imem_data : ir_q;
    opc   = word[6:0];
    f3    = word[14:12];
    f7    = word[31:25];
    imm_i = {{(PC_W-12){word[31]}}, word[31:20]};
    imm_s = {{(PC_W-12){word[31]}}, word[31:25], word[11:7]};
    imm_b = {{(PC_W-13){word[31]}}, word[31], word[7], word[30:25], word[11:8], 1'b0};

    dec_legal = 1'b0;
    dec_wreg  = 1'b0;
    dec_wmem  = 1'b0;
    dec_br    = 1'b0;
    dec_sub   = 1'b0;
    dec_ra    = word[19:15];
    dec_rb    = word[24:20];
    dec_rw    = word[11:7];
    dec_off   = '0;
    dec_op    = 2'd0;

    case (opc)
      OPC_REG: begin
        if (f3 == 3'b000 && (f7 == 7'b0000000 || f7 == 7'b0100000)) begin
          dec_legal = 1'b1;
          dec_wreg  = 1'b1;
          dec_sub   = f7[5];
        end
      end
      OPC_ADDI, OPC_SUBI: begin
        if (f3 == 3'b000) begin
          dec_legal = 1'b1;
          dec_wreg  = 1'b1;
          dec_op    = 2'd2;
          dec_sub   = (opc == OPC_SUBI);
          dec_off   = imm_i;
        end
      end
      OPC_LOAD: begin
        if (f3 == 3'b011) begin
          dec_legal = 1'b1;
          dec_wreg  = 1'b1;
          dec_rb    = word[19:15];
          dec_op    = 2'd1;
          dec_off   = imm_i;
        end
      end
      OPC_STORE: begin
        if (f3 == 3'b011) begin
          dec_legal = 1'b1;
          dec_wmem  = 1'b1;
          dec_ra    = word[24:20];
          dec_rb    = word[19:15];
          dec_op    = 2'd1;
          dec_off   = imm_s;
        end
      end
      OPC_BRANCH: begin
        if (f3 != 3'b010 && f3 != 3'b011) begin
          dec_legal = 1'b1;
          dec_br    = 1'b1;
          dec_off   = imm_b;
        end
      end
      default: dec_legal = 1'b0;
    endcase
  end

  always_comb begin
    case (ir_q[14:12])
      3'b000:  br_taken = flags[0];
      3'b001:  br_taken = flags[1];
      3'b100:  br_taken = flags[2];
      3'b101:  br_taken = flags[3];
      3'b110:  br_taken = flags[4];
      3'b111:  br_taken = flags[5];
      default: br_taken = 1'b0;
    endcase
  end

  assign pc_seq_d = pc_q + PC_W'(4);
  assign pc_tgt_d = pc_q + off_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      ra_q      <= '0;
      rb_q      <= '0;
      rw_q      <= '0;
      off_q     <= '0;
      op_q      <= 2'd0;
      sub_q     <= 1'b0;
      we_reg_q  <= 1'b0;
      we_mem_q  <= 1'b0;
      req_q     <= 1'b1;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (imem_valid) begin
            ir_q    <= imem_data;
            ra_q    <= dec_ra;
            rb_q    <= dec_rb;
            rw_q    <= dec_rw;
            off_q   <= dec_off;
            op_q    <= dec_op;
            sub_q   <= dec_sub;
            req_q   <= 1'b0;
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (!dec_legal) begin
            halted_q  <= 1'b1;
            illegal_q <= 1'b1;
            state_q   <= S_HALT;
          end else begin
            we_reg_q <= dec_wreg && (dec_rw != 5'd0);
            we_mem_q <= dec_wmem;
            state_q  <= S_EXEC;
          end
        end
        S_EXEC: begin
          we_reg_q <= 1'b0;
          we_mem_q <= 1'b0;
          // A taken branch to a misaligned target stops the core without moving pc.
          if (dec_br && br_taken && pc_tgt_d[1:0] != 2'b00) begin
            halted_q  <= 1'b1;
            illegal_q <= 1'b1;
            state_q   <= S_HALT;
          end else begin
            pc_q    <= (dec_br && br_taken) ? pc_tgt_d : pc_seq_d;
            req_q   <= 1'b1;
            state_q <= S_FETCH;
          end
        end
        default: state_q <= S_HALT;
      endcase
    end
  end

  assign imem_addr = pc_q;
  assign imem_req  = req_q;
  assign pc        = pc_q;
  assign Ra        = ra_q;
  assign Rb        = rb_q;
  assign Rw        = rw_q;
  assign OFFSET    = off_q;
  assign OP_MEM_I  = op_q;
  assign ADD_SUB   = sub_q;
  assign WE_reg    = we_reg_q;
  assign WE_mem    = we_mem_q;
  assign halted    = halted_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_uc_multiciclo.sv
// tb/tb_uc_multiciclo.sv - bench for uc_multiciclo: instruction table with scoreboard plus reset/stall/halt sequences
module tb_uc_multiciclo;

  logic        clk;
  logic        rst_n;
  logic [63:0] imem_addr;
  logic        imem_req;
  logic        imem_valid;
  logic [31:0] imem_data;
  logic [4:0]  Ra, Rb, Rw;
  logic        WE_reg, WE_mem;
  logic [63:0] OFFSET;
  logic [1:0]  OP_MEM_I;
  logic        ADD_SUB;
  logic [5:0]  flags;
  logic [63:0] pc;
  logic        halted, illegal;

  uc_multiciclo #(.PC_W(64), .RESET_PC(64'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(imem_addr), .imem_req(imem_req), .imem_valid(imem_valid), .imem_data(imem_data),
    .Ra(Ra), .Rb(Rb), .Rw(Rw), .WE_reg(WE_reg), .WE_mem(WE_mem),
    .OFFSET(OFFSET), .OP_MEM_I(OP_MEM_I), .ADD_SUB(ADD_SUB), .flags(flags),
    .pc(pc), .halted(halted), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [5:0]  flg;
    logic [2:0]  mask;
    logic [4:0]  ra, rb, rw;
    logic [63:0] off;
    logic [1:0]  op;
    logic        sub, wreg, wmem;
    logic [63:0] pc_next;
  } vec_t;

  vec_t vecs[10];
  vec_t exp_q[$];
  int total = 0;
  int bad = 0;
  logic [63:0] exp_pc;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    vec_t e;
    chk("fetch_req", imem_req, 1);
    chk("fetch_addr", imem_addr, exp_pc);
    imem_valid = 1'b1;
    imem_data  = v.instr;
    exp_q.push_back(v);
    step();
    imem_valid = 1'b0;
    imem_data  = 32'hDEAD_BEEF;
    e = exp_q.pop_front();
    if (e.mask[2]) chk("dec_Ra", Ra, e.ra);
    if (e.mask[1]) chk("dec_Rb", Rb, e.rb);
    if (e.mask[0]) chk("dec_Rw", Rw, e.rw);
    chk("dec_OFFSET", OFFSET, e.off);
    chk("dec_OP_MEM_I", OP_MEM_I, e.op);
    chk("dec_ADD_SUB", ADD_SUB, e.sub);
    chk("dec_WE", {WE_reg, WE_mem}, 2'b00);
    flags = e.flg;
    step();
    chk("exec_WE_reg", WE_reg, e.wreg);
    chk("exec_WE_mem", WE_mem, e.wmem);
    if (e.mask[0]) chk("exec_Rw", Rw, e.rw);
    chk("exec_OFFSET", OFFSET, e.off);
    step();
    flags = 6'b0;
    chk("next_pc", pc, e.pc_next);
    chk("after_WE", {WE_reg, WE_mem}, 2'b00);
    chk("after_halted", halted, 0);
    exp_pc = e.pc_next;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_WE", {WE_reg, WE_mem}, 2'b00);
    chk("rst_pc", pc, 64'h0);
    chk("rst_flags", {halted, illegal}, 2'b00);
    step();
    rst_n = 1'b1;
    exp_pc = 64'h0;
  endtask

  initial begin
    //          instr          flags      mask    ra  rb  rw  offset                 op sub wr wm  next pc
    vecs[0] = '{32'h00700293, 6'b000000, 3'b101, 0,  0,  5,  64'd7,                 2, 0,  1, 0, 64'h04};
    vecs[1] = '{32'h00513423, 6'b000000, 3'b110, 5,  2,  0,  64'd8,                 1, 0,  0, 1, 64'h08};
    vecs[2] = '{32'hFFF0818B, 6'b000000, 3'b101, 1,  0,  3,  64'hFFFFFFFFFFFFFFFF,  2, 1,  1, 0, 64'h0C};
    vecs[3] = '{32'h0101B383, 6'b000000, 3'b011, 0,  3,  7,  64'd16,                1, 0,  1, 0, 64'h10};
    vecs[4] = '{32'hFE208CE3, 6'b000001, 3'b110, 1,  2,  0,  64'hFFFFFFFFFFFFFFF8,  0, 0,  0, 0, 64'h08};
    vecs[5] = '{32'h00208033, 6'b000000, 3'b111, 1,  2,  0,  64'd0,                 0, 0,  0, 0, 64'h0C};
    vecs[6] = '{32'h40208333, 6'b000000, 3'b111, 1,  2,  6,  64'd0,                 0, 1,  1, 0, 64'h10};
    vecs[7] = '{32'hFE208CE3, 6'b000010, 3'b110, 1,  2,  0,  64'hFFFFFFFFFFFFFFF8,  0, 0,  0, 0, 64'h14};
    vecs[8] = '{32'hFE20ECE3, 6'b010000, 3'b110, 1,  2,  0,  64'hFFFFFFFFFFFFFFF8,  0, 0,  0, 0, 64'h0C};
    vecs[9] = '{32'hFE20DCE3, 6'b110111, 3'b110, 1,  2,  0,  64'hFFFFFFFFFFFFFFF8,  0, 0,  0, 0, 64'h10};

    rst_n      = 1'b0;
    imem_valid = 1'b0;
    imem_data  = 32'h0;
    flags      = 6'b0;
    exp_pc     = 64'h0;
    repeat (3) step();
    chk("rst_pc", pc, 64'h0);
    chk("rst_WE", {WE_reg, WE_mem}, 2'b00);
    chk("rst_ctrl", {Ra, Rb, Rw, OP_MEM_I, ADD_SUB}, 18'h0);
    chk("rst_OFFSET", OFFSET, 64'h0);
    chk("rst_status", {halted, illegal}, 2'b00);
    rst_n = 1'b1;
    step();
    chk("post_rst_req", imem_req, 1);
    chk("post_rst_addr", imem_addr, 64'h0);

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Fetch stall: request and address must hold, no write enables, garbage data ignored.
    imem_data = 32'h00513423;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_req", imem_req, 1);
      chk("stall_addr", imem_addr, exp_pc);
      chk("stall_WE", {WE_reg, WE_mem}, 2'b00);
    end

    // Reset asserted during EXEC of a store drops WE_mem immediately.
    imem_valid = 1'b1;
    imem_data  = 32'h00513423;
    step();
    imem_valid = 1'b0;
    step();
    chk("store_exec_WE_mem", WE_mem, 1);
    #2;
    do_reset();
    chk("rst_release_req", imem_req, 1);

    // Taken branch to a misaligned target halts without moving pc.
    imem_valid = 1'b1;
    imem_data  = 32'h00000163;
    step();
    imem_valid = 1'b0;
    flags = 6'b000001;
    step();
    step();
    flags = 6'b0;
    chk("misalign_status", {halted, illegal}, 2'b11);
    chk("misalign_pc", pc, 64'h0);
    chk("misalign_req", imem_req, 0);
    #2;
    do_reset();

    // Illegal encoding halts; the stopped core ignores further fetch traffic.
    imem_valid = 1'b1;
    imem_data  = 32'hFFFFFFFF;
    step();
    imem_data  = 32'h00700293;
    step();
    chk("illegal_status", {halted, illegal}, 2'b11);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("halt_req", imem_req, 0);
      chk("halt_pc", pc, 64'h0);
      chk("halt_WE", {WE_reg, WE_mem}, 2'b00);
      chk("halt_hold", {halted, illegal}, 2'b11);
    end
    imem_valid = 1'b0;
    #2;
    do_reset();
    chk("cleared_status", {halted, illegal}, 2'b00);
    chk("cleared_req", imem_req, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uc_multiciclo.md
Name: uc_multiciclo

Overview:
- Multicycle control unit for the 64-bit processor; drives the FD datapath and consumes its branch flags.
- Fetches 32-bit RV64-subset instructions through a req/valid instruction-memory port and holds them in an instruction register (IR).
- Decodes each instruction into the datapath controls (Ra, Rb, Rw, WE_reg, WE_mem, OFFSET, OP_MEM_I, ADD_SUB) and updates the PC.

Parameters:
- RESET_PC, 64'h0: PC value after reset.
- PC_W, 64: PC and OFFSET width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_addr  out  PC_W  fetch address, equal to PC.
- imem_req  out  1  fetch request.
- imem_valid  in  1  instruction word valid.
- imem_data  in  32  instruction word.
- Ra, Rb, Rw  out  5  register addresses to the datapath.
- WE_reg  out  1  register-file write enable.
- WE_mem  out  1  data-memory write enable.
- OFFSET  out  64  sign-extended immediate.
- OP_MEM_I  out  2  datapath operation select:
  - 0: reg add/sub
  - 1: load/store address = doutB+OFFSET
  - 2: addi/subi = doutA±OFFSET
- ADD_SUB  out  1  0 = add, 1 = subtract.
- flags  in  6  comparison flags from the datapath, computed on doutA vs doutB:
  - [0] equal
  - [1] not equal
  - [2] signed less-than
  - [3] signed greater-or-equal
  - [4] unsigned less-than
  - [5] unsigned greater-or-equal
- pc  out  PC_W  current PC.
- halted  out  1  core stopped.
- illegal  out  1  stopped on an illegal instruction or misaligned branch target.

Behaviour:
- Reset (asynchronous, while rst_n=0):
  - state=FETCH, pc=RESET_PC, IR=0, halted=0, illegal=0.
  - WE_reg=WE_mem=0 immediately, including when reset arrives mid-instruction.
  - Ra=Rb=Rw=0, OFFSET=0, OP_MEM_I=0, ADD_SUB=0.
- FETCH:
  - imem_req=1; imem_addr=pc, held stable until imem_valid.
  - On imem_valid=1: IR<=imem_data, go to DECODE.
  - imem_valid is ignored whenever imem_req=0.
- DECODE (1 cycle):
  - Ra/Rb/Rw/OFFSET/OP_MEM_I/ADD_SUB are driven from IR; no write enables.
  - An illegal encoding goes to HALT; otherwise go to EXEC.
- EXEC (1 cycle): control outputs are held as in DECODE, then:
  - ALU or load: WE_reg=1 for exactly this cycle, suppressed when Rw=0.
  - Store: WE_mem=1 for exactly this cycle.
  - Branch: pc<=pc+OFFSET if taken, else pc+4.
  - All other instructions: pc<=pc+4.
  - Next state: FETCH.
- Timing: minimum 3 cycles per instruction (FETCH, DECODE, EXEC) when imem_valid=1 in the first FETCH cycle.
- Decode table (opcode/funct3/funct7). Unless noted, Ra=rs1, Rb=rs2, Rw=rd.
  - ADD 0110011/000/0000000: OP_MEM_I=0, ADD_SUB=0.
  - SUB 0110011/000/0100000: OP_MEM_I=0, ADD_SUB=1.
  - ADDI 0010011/000: OP_MEM_I=2, ADD_SUB=0, OFFSET=sext(I-imm).
  - SUBI 0001011/000: OP_MEM_I=2, ADD_SUB=1, OFFSET=sext(I-imm).
  - LD 0000011/011: Rb=rs1, Rw=rd, OP_MEM_I=1, OFFSET=sext(I-imm).
  - SD 0100011/011: Ra=rs2 (data), Rb=rs1 (base), OP_MEM_I=1, OFFSET=sext(S-imm).
  - Branches 1100011, OP_MEM_I=0, OFFSET=sext(B-imm), taken when the listed flag is 1:
    - BEQ 000: flags[0]
    - BNE 001: flags[1]
    - BLT 100: flags[2]
    - BGE 101: flags[3]
    - BLTU 110: flags[4]
    - BGEU 111: flags[5]
  - Any other encoding is illegal.
- HALT:
  - Entered on an illegal encoding, or on a taken branch whose target[1:0]!=0 (pc is not updated).
  - halted=1; illegal=1.
  - imem_req=0, WE_reg=WE_mem=0, pc frozen.
  - Left only by reset.
- Arithmetic: pc+4 and pc+OFFSET wrap modulo 2^PC_W; flags are sampled only in EXEC.

Test Plan:
- Reset: rst_n=0 for 3 cycles, then release -> pc=0, imem_req=1, imem_addr=0, all WE=0; asserting rst_n=0 during EXEC of a store drops WE_mem in the same cycle.
- ADDI x5,x0,7 (0x00700293), imem_valid immediate:
  - DECODE: Ra=0, OFFSET=7, OP_MEM_I=2, ADD_SUB=0.
  - EXEC: WE_reg=1, Rw=5, for one cycle.
  - pc 0->4 after 3 cycles.
- SD x5,8(x2) (0x00513423) -> Ra=5, Rb=2, OFFSET=8, OP_MEM_I=1, WE_mem=1 for one cycle, WE_reg=0.
- BEQ x1,x2,-8 at pc=0x10:
  - flags[0]=1 -> pc=0x08.
  - flags=6'b000010 -> pc=0x14.
  - BLTU with flags[4]=1 -> taken.
- ADD x0,x1,x2 -> WE_reg stays 0 throughout; imem_valid held low for 5 cycles -> imem_req/imem_addr stable and no WE asserted.
- Fetch 0xFFFFFFFF -> halted=1, illegal=1, imem_req=0 thereafter; reset clears both.
